// File: rtl/noc_vc_output_arbiter_pkg.sv
// Shared types for the VC output arbiter: flit layout, VC index, FSM states.
package noc_vc_output_arbiter_pkg;

    localparam int DEF_CHANNELS = 32;
    localparam int DEF_FLIT_W   = 64;
    localparam int DEF_VC_W     = $clog2(DEF_CHANNELS);

    typedef logic [DEF_VC_W-1:0] vc_idx_t;

    // Default-width flit view: head in the MSB, tail just below it.
    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [DEF_FLIT_W-3:0] payload;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Circular increment of an index in [0, n).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational N-way round-robin pick: first request at or after ptr, circularly.
module noc_rr_arbiter
    import noc_vc_output_arbiter_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned pos;

    // Scan all N positions starting at ptr and keep the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 32'(ptr);
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && req[pos[IDX_W-1:0]]) begin
                any                 = 1'b1;
                idx                 = pos[IDX_W-1:0];
                gnt[pos[IDX_W-1:0]] = 1'b1;
            end
            pos = wrap_inc(pos, N);
        end
    end

endmodule

// File: rtl/noc_vc_output_arbiter.sv
// Packet-level round-robin VC arbiter with wormhole lock and a one-entry
// registered output stage feeding the switch.
module noc_vc_output_arbiter
    import noc_vc_output_arbiter_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int FLIT_W   = 64,
    parameter int VC_W     = $clog2(CHANNELS)
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic [CHANNELS-1:0]        i_vc_valid,
    input  logic [CHANNELS*FLIT_W-1:0] i_vc_flit,
    output logic [CHANNELS-1:0]        o_vc_ready,
    output logic                       o_valid,
    output logic [FLIT_W-1:0]          o_flit,
    output logic [VC_W-1:0]            o_vc_id,
    input  logic                       i_ready,
    output logic                       o_locked,
    output logic                       o_proto_err
);

    arb_state_e          state_q, state_d;
    logic [VC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]     lock_vc_q, lock_vc_d;
    logic                o_valid_q, o_valid_d;
    logic [FLIT_W-1:0]   o_flit_q, o_flit_d;
    logic [VC_W-1:0]     o_vc_id_q, o_vc_id_d;
    logic                err_q, err_d;

    logic [FLIT_W-1:0]   flit_arr [CHANNELS];
    logic [CHANNELS-1:0] head_v;
    logic [CHANNELS-1:0] tail_v;

    logic [CHANNELS-1:0] arb_gnt;
    logic [VC_W-1:0]     arb_idx;
    logic                arb_any;

    logic                load;
    logic                grant;
    logic [VC_W-1:0]     gidx;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign flit_arr[i] = i_vc_flit[i*FLIT_W +: FLIT_W];
        assign head_v[i]   = flit_arr[i][FLIT_W-1];
        assign tail_v[i]   = flit_arr[i][FLIT_W-2];
    end

    noc_rr_arbiter #(
        .N     (CHANNELS),
        .IDX_W (VC_W)
    ) u_rr (
        .req (i_vc_valid & head_v),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign load = !o_valid_q || i_ready;

    // Next-state, pop strobes and output-register load decision.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = lock_vc_q;
        o_valid_d  = o_valid_q;
        o_flit_d   = o_flit_q;
        o_vc_id_d  = o_vc_id_q;
        err_d      = err_q;
        o_vc_ready = '0;
        grant      = 1'b0;
        gidx       = '0;

        case (state_q)
            IDLE: begin
                // No packet is open anywhere, so any valid non-head flit is stray.
                if (|(i_vc_valid & ~head_v)) begin
                    err_d = 1'b1;
                end
                if (load && arb_any) begin
                    grant      = 1'b1;
                    gidx       = arb_idx;
                    o_vc_ready = arb_gnt;
                    if (tail_v[arb_idx]) begin
                        rr_ptr_d = VC_W'(wrap_inc(32'(arb_idx), CHANNELS));
                    end else begin
                        lock_vc_d = arb_idx;
                        state_d   = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (load && i_vc_valid[lock_vc_q]) begin
                    grant                 = 1'b1;
                    gidx                  = lock_vc_q;
                    o_vc_ready[lock_vc_q] = 1'b1;
                    if (head_v[lock_vc_q]) begin
                        err_d = 1'b1;
                    end
                    if (tail_v[lock_vc_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = VC_W'(wrap_inc(32'(lock_vc_q), CHANNELS));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            o_valid_d = grant;
            if (grant) begin
                o_flit_d  = flit_arr[gidx];
                o_vc_id_d = gidx;
            end
        end

        if (!noc_rst_n) begin
            o_vc_ready = '0;
        end
    end

    // State, pointer, output register and sticky error flag.
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_vc_q <= '0;
            o_valid_q <= 1'b0;
            o_flit_q  <= '0;
            o_vc_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            o_valid_q <= o_valid_d;
            o_flit_q  <= o_flit_d;
            o_vc_id_q <= o_vc_id_d;
            err_q     <= err_d;
        end
    end

    assign o_valid     = o_valid_q;
    assign o_flit      = o_flit_q;
    assign o_vc_id     = o_vc_id_q;
    assign o_locked    = (state_q == LOCKED);
    assign o_proto_err = err_q;

endmodule
